// File: rtl/hbm_back_packer_if.sv
// Bundle of the job-control, result-stream and write-back beat signals
// between the SGD engine / write-back stage and hbm_back_packer.
interface hbm_back_packer_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 512
);
  logic                 start;
  logic [31:0]          data_length;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] back_data;
  logic                 back_valid;
  logic                 almost_full;
  logic                 busy;
  logic                 done;

  // Packer side
  modport slave (
    input  start, data_length, in_data, in_valid, almost_full,
    output in_ready, back_data, back_valid, busy, done
  );

  // Engine / write-back side
  modport master (
    output start, data_length, in_data, in_valid, almost_full,
    input  in_ready, back_data, back_valid, busy, done
  );
endinterface

// File: rtl/hbm_back_packer.sv
// Packs 32-bit SGD results into 512-bit HBM write-back beats.
// A start pulse arms a job of data_length bytes; the last partial beat is
// zero-padded and done pulses together with the final beat strobe.
module hbm_back_packer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 512
) (
  input  logic               hbm_clk,
  input  logic               hbm_aresetn,
  hbm_back_packer_if.slave   bus
);
  localparam int LANES  = OUT_WIDTH / IN_WIDTH;
  localparam int LANE_W = $clog2(LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [LANE_W-1:0]    idx_q, idx_d;
  logic [32:0]          cnt_q, cnt_d;
  logic [32:0]          total_q, total_d;
  logic [OUT_WIDTH-1:0] pack_q, pack_d;
  logic [OUT_WIDTH-1:0] back_data_q, back_data_d;
  logic                 back_valid_q, back_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [32:0]          total_words_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic [OUT_WIDTH-1:0] pack_ins_s;

  // Word count of the requested job (33 bits so an all-ones length cannot wrap)
  // and the combinational accept handshake gated by downstream almost_full.
  always_comb begin
    total_words_s = ({1'b0, bus.data_length} + 33'd3) >> 2;
    in_ready_s    = (state_q == ST_PACK) && !bus.almost_full && (cnt_q < total_q);
    accept_s      = in_ready_s && bus.in_valid;
  end

  // Pack register with the incoming word dropped into the current lane.
  always_comb begin
    pack_ins_s = pack_q;
    for (int k = 0; k < LANES; k++) begin
      if (idx_q == LANE_W'(k)) begin
        pack_ins_s[k*IN_WIDTH +: IN_WIDTH] = bus.in_data;
      end else begin
        pack_ins_s[k*IN_WIDTH +: IN_WIDTH] = pack_q[k*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  // Job sequencing: lane/word bookkeeping, beat emission and end-of-job.
  // Unused upper lanes are already zero because the pack register is cleared
  // at job start and after each emitted beat.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    total_d      = total_q;
    pack_d       = pack_q;
    back_data_d  = back_data_q;
    back_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          total_d = total_words_s;
          idx_d   = '0;
          cnt_d   = 33'd0;
          pack_d  = '0;
          if (total_words_s != 33'd0) begin
            state_d = ST_PACK;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PACK: begin
        if (accept_s) begin
          cnt_d = cnt_q + 33'd1;
          if ((cnt_q + 33'd1) == total_q) begin
            back_data_d  = pack_ins_s;
            back_valid_d = 1'b1;
            pack_d       = '0;
            idx_d        = '0;
            state_d      = ST_LAST;
          end else if (idx_q == LAST_LANE) begin
            back_data_d  = pack_ins_s;
            back_valid_d = 1'b1;
            pack_d       = '0;
            idx_d        = '0;
          end else begin
            pack_d = pack_ins_s;
            idx_d  = idx_q + LANE_W'(1);
          end
        end else begin
          state_d = ST_PACK;
        end
      end
      ST_LAST: state_d = ST_IDLE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_LAST) || (state_d == ST_DONE);
  end

  // State and registered outputs; reset discards any partial beat.
  always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
    if (!hbm_aresetn) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= 33'd0;
      total_q      <= 33'd0;
      pack_q       <= '0;
      back_data_q  <= '0;
      back_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      total_q      <= total_d;
      pack_q       <= pack_d;
      back_data_q  <= back_data_d;
      back_valid_q <= back_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.back_data  = back_data_q;
  assign bus.back_valid = back_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule
